alu_divider: RTL and testbench
==============================

ALU_DIVIDER -- requirements
Module: alu_divider

Interface
REQ-001 Parameter: WIDTH, 16, operand and result width in bits; only 16 is verified.
REQ-002 Clk  input  1  sole clock, all state updates on the rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 Start  input  1  request to begin a division; sampled only in IDLE.
REQ-005 Signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with Start.
REQ-006 A  input  WIDTH  dividend; sampled with Start.
REQ-007 B  input  WIDTH  divisor; sampled with Start.
REQ-008 Busy  output  1  high while a division is in progress.
REQ-009 Done  output  1  one-cycle pulse when results become valid.
REQ-010 Quotient  output  WIDTH  result quotient.
REQ-011 Remainder  output  WIDTH  result remainder.
REQ-012 DivByZero  output  1  set when B was zero.
REQ-013 Overflow  output  1  set for signed most-negative / -1.

Function
REQ-014 The FSM shall have three states: IDLE, RUN and DONE.
REQ-015 IDLE: Start=1 with B!=0 -> RUN; capture |A|, |B|, Signed and the result signs; clear the iteration counter.
REQ-016 IDLE: Start=1 with B=0 -> DONE.
REQ-017 RUN: one restoring shift-subtract iteration per clock, MSB first; 17-bit partial remainder minus 17-bit divisor; on no borrow keep the difference and shift in quotient bit 1, else restore and shift in 0.
REQ-018 RUN -> DONE after exactly WIDTH iterations, counter 0..15; there is no early termination.
REQ-019 DONE: Done=1 for exactly one cycle, then -> IDLE unconditionally; Start is ignored in DONE.
REQ-020 Latency: Done shall be high in the cycle after the 16th rising edge following the Start-sampling edge; for B=0 it shall be high in the cycle after the 1st edge.
REQ-021 Busy shall be 1 in RUN only; Start while Busy or in DONE is ignored, and the captured operands are not disturbed.
REQ-022 Signed mode: the quotient truncates toward zero; the quotient is negated when the operand signs differ; the remainder takes the sign of A.
REQ-023 Unsigned mode: no negation; full 0..65535 range.
REQ-024 B=0: Quotient=0xFFFF, Remainder=A, DivByZero=1, Overflow=0.
REQ-025 Signed A=0x8000, B=0xFFFF: Quotient=0x8000, Remainder=0x0000, Overflow=1, DivByZero=0; this case runs the full 16 iterations.
REQ-026 Quotient, Remainder, DivByZero and Overflow shall update only on entry to DONE and hold until the next DONE entry.
REQ-027 The 16-bit magnitude of 0x8000 shall be handled without loss; the internal datapath is 17 bits wide.

Reset
REQ-028 Reset=1 shall force, immediately and independent of Clk: state IDLE, Busy=0, Done=0, Quotient=0, Remainder=0, DivByZero=0, Overflow=0, counter=0.
REQ-029 Reset asserted mid-RUN shall abort the division with no Done pulse; the first Start after deassertion starts a fresh division.

Structure
REQ-030 Shared package alu_pkg shall hold the WIDTH default, the FSM state encoding, and the constants for the div-by-zero quotient (0xFFFF) and the most-negative value (0x8000).
REQ-031 Sub-module div_subtractor (17-bit ripple subtractor with borrow-out) shall be instantiated once in the iteration datapath; all sequencing stays in alu_divider.

Verification
REQ-032 Unsigned 100/7 -> Quotient=14, Remainder=2, Done exactly 16 cycles after Start, Busy high for 16 cycles.
REQ-033 Signed 0xFFF9/0x0002 (-7/2) -> Quotient=0xFFFD, Remainder=0xFFFF; unsigned 0xFFFF/0x0001 -> Quotient=0xFFFF, Remainder=0.
REQ-034 0x1234/0 (either mode) -> Quotient=0xFFFF, Remainder=0x1234, DivByZero=1, Done one cycle after Start, Busy never high.
REQ-035 Signed 0x8000/0xFFFF -> Quotient=0x8000, Remainder=0, Overflow=1 after 16 cycles.
REQ-036 Start pulsed at RUN cycle 5 with different operands -> original result is unchanged; Reset at RUN cycle 8 -> all outputs 0 and no Done pulse; next Start of 9/3 -> Quotient=3, Remainder=0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared width default, FSM encoding and divider constants
package alu_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Quotient reported for a zero divisor
    localparam logic [DEFAULT_WIDTH-1:0] DIV_ZERO_Q = 16'hFFFF;
    // Most-negative two's-complement value, whose magnitude needs the extra datapath bit
    localparam logic [DEFAULT_WIDTH-1:0] MOST_NEG = 16'h8000;

endpackage

// File: rtl/div_subtractor.sv
// div_subtractor: ripple-borrow subtractor producing a - b and the borrow out
module div_subtractor #(
    parameter int N = 17
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);

    logic [N:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign diff[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & c[i]);
    end

    assign borrow = c[N];

endmodule

// File: rtl/alu_divider.sv
// alu_divider: signed/unsigned restoring divider, one quotient bit per clock
module alu_divider
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivByZero,
    output logic             Overflow
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic [WIDTH:0]   d;
    logic             neg_q;
    logic             neg_r;
    logic             ovf;

    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] r_mag;
    logic             unused_r_top;

    // Magnitudes; -0x8000 wraps back to 0x8000, which is the correct unsigned magnitude
    assign abs_a = (Signed && A[WIDTH-1]) ? -A : A;
    assign abs_b = (Signed && B[WIDTH-1]) ? -B : B;

    // Bring down the next dividend bit, MSB first
    assign shifted = {r, q[WIDTH-1]};

    div_subtractor #(.N(WIDTH + 1)) u_sub (
        .a      (shifted),
        .b      (d),
        .diff   (diff),
        .borrow (borrow)
    );

    // Restoring step: keep the difference only when the subtraction did not borrow
    assign r_next       = borrow ? shifted : diff;
    assign q_next       = {q[WIDTH-2:0], ~borrow};
    assign r_mag        = r_next[WIDTH-1:0];
    assign unused_r_top = r_next[WIDTH];

    // Sequencer: captures operands in IDLE, iterates in RUN, pulses Done in DONE
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Quotient  <= '0;
            Remainder <= '0;
            DivByZero <= 1'b0;
            Overflow  <= 1'b0;
            count     <= '0;
            q         <= '0;
            r         <= '0;
            d         <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    Done <= 1'b0;
                    if (Start && B == '0) begin
                        state     <= DONE;
                        Done      <= 1'b1;
                        Quotient  <= DIV_ZERO_Q;
                        Remainder <= A;
                        DivByZero <= 1'b1;
                        Overflow  <= 1'b0;
                    end else if (Start) begin
                        state <= RUN;
                        Busy  <= 1'b1;
                        count <= '0;
                        q     <= abs_a;
                        r     <= '0;
                        d     <= {1'b0, abs_b};
                        neg_q <= Signed && (A[WIDTH-1] ^ B[WIDTH-1]);
                        neg_r <= Signed && A[WIDTH-1];
                        ovf   <= Signed && A == MOST_NEG && B == '1;
                    end
                end
                RUN: begin
                    q     <= q_next;
                    r     <= r_mag;
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        state     <= DONE;
                        Busy      <= 1'b0;
                        Done      <= 1'b1;
                        Quotient  <= neg_q ? -q_next : q_next;
                        Remainder <= neg_r ? -r_mag : r_mag;
                        DivByZero <= 1'b0;
                        Overflow  <= ovf;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    Done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_divider.sv
// tb_alu_divider: randomized and directed checks of alu_divider against an arithmetic model
module tb_alu_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sgn;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] quo;
    logic [15:0] rem;
    logic        dbz;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    alu_divider #(.WIDTH(16)) dut (
        .Clk       (clk),
        .Reset     (rst),
        .Start     (start),
        .Signed    (sgn),
        .A         (a),
        .B         (b),
        .Busy      (busy),
        .Done      (done),
        .Quotient  (quo),
        .Remainder (rem),
        .DivByZero (dbz),
        .Overflow  (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: integer division truncates toward zero and % follows the dividend sign
    function automatic void model(input logic s, input logic [15:0] x, input logic [15:0] y,
                                  output logic [15:0] mq, output logic [15:0] mr,
                                  output logic mdz, output logic mov);
        int sx;
        int sy;
        if (y == 16'h0) begin
            mq = 16'hFFFF; mr = x; mdz = 1'b1; mov = 1'b0;
        end else if (s) begin
            sx = int'($signed(x));
            sy = int'($signed(y));
            mq = 16'(sx / sy); mr = 16'(sx % sy); mdz = 1'b0;
            mov = (x == 16'h8000) && (y == 16'hFFFF);
        end else begin
            mq = x / y; mr = x % y; mdz = 1'b0; mov = 1'b0;
        end
    endfunction

    // Issues one division and measures edges to Done, Busy samples and the cycle after Done
    task automatic do_div(input logic s, input logic [15:0] x, input logic [15:0] y,
                          output int lat, output int bcnt, output logic [33:0] res,
                          output logic done_after);
        @(negedge clk);
        start = 1'b1; sgn = s; a = x; b = y;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        bcnt = 0;
        while (!done && lat < 40) begin
            bcnt += int'(busy);
            @(posedge clk);
            #1 lat++;
        end
        res = {quo, rem, dbz, ovf};
        @(posedge clk);
        #1 done_after = done;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
        #12;
        checks++;
        if ({busy, done, quo, rem, dbz, ovf} !== 36'h0) begin
            errors++;
            $display("FAIL reset_state got %h want 0", {busy, done, quo, rem, dbz, ovf});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [32:0] vecs [8] = '{
            {1'b0, 16'd100,   16'd7},
            {1'b1, 16'hFFF9,  16'h0002},
            {1'b0, 16'hFFFF,  16'h0001},
            {1'b0, 16'h1234,  16'h0000},
            {1'b1, 16'h1234,  16'h0000},
            {1'b1, 16'h8000,  16'hFFFF},
            {1'b0, 16'h8000,  16'hFFFF},
            {1'b1, 16'h8000,  16'h0003}
        };
        int lat, bcnt, wl, wb;
        logic [33:0] res, want;
        logic da;
        logic [15:0] mq, mr;
        logic mdz, mov;
        for (int i = 0; i < 8; i++) begin
            do_div(vecs[i][32], vecs[i][31:16], vecs[i][15:0], lat, bcnt, res, da);
            model(vecs[i][32], vecs[i][31:16], vecs[i][15:0], mq, mr, mdz, mov);
            want = {mq, mr, mdz, mov};
            wl = (vecs[i][15:0] == 16'h0) ? 0 : 16;
            wb = wl;
            checks++;
            if (res !== want) begin
                errors++;
                $display("FAIL directed_result[%0d] got %h want %h", i, res, want);
            end
            checks++;
            if (lat !== wl || bcnt !== wb || da !== 1'b0) begin
                errors++;
                $display("FAIL directed_timing[%0d] got lat=%0d busy=%0d done_next=%b want lat=%0d busy=%0d done_next=0",
                         i, lat, bcnt, da, wl, wb);
            end
            checks++;
            if ({quo, rem, dbz, ovf} !== want) begin
                errors++;
                $display("FAIL directed_hold[%0d] got %h want %h", i, {quo, rem, dbz, ovf}, want);
            end
        end
    endtask

    task automatic test_random();
        int lat, bcnt, wl;
        logic [33:0] res, want;
        logic da, s;
        logic [15:0] x, y, mq, mr;
        logic mdz, mov;
        for (int i = 0; i < 60; i++) begin
            s = 1'($urandom_range(0, 1));
            x = 16'($urandom_range(0, 65535));
            case ($urandom_range(0, 9))
                0: y = 16'h0000;
                1: y = 16'hFFFF;
                2: y = 16'($urandom_range(1, 15));
                default: y = 16'($urandom_range(1, 65535));
            endcase
            if (i % 15 == 0) x = 16'h8000;
            do_div(s, x, y, lat, bcnt, res, da);
            model(s, x, y, mq, mr, mdz, mov);
            want = {mq, mr, mdz, mov};
            wl = (y == 16'h0) ? 0 : 16;
            checks++;
            if (res !== want) begin
                errors++;
                $display("FAIL random_result[%0d] s=%b %h/%h got %h want %h", i, s, x, y, res, want);
            end
            checks++;
            if (lat !== wl || bcnt !== wl || da !== 1'b0) begin
                errors++;
                $display("FAIL random_timing[%0d] got lat=%0d busy=%0d done_next=%b want lat=%0d busy=%0d",
                         i, lat, bcnt, da, wl, wl);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [15:0] mq, mr;
        logic mdz, mov;
        @(negedge clk);
        start = 1'b1; sgn = 1'b0; a = 16'd1000; b = 16'd9;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            if (lat == 5) begin
                start = 1'b1; sgn = 1'b1; a = 16'hFF00; b = 16'h0000;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1 lat++;
        end
        start = 1'b1; a = 16'd7; b = 16'd0;
        model(1'b0, 16'd1000, 16'd9, mq, mr, mdz, mov);
        checks++;
        if ({quo, rem, dbz, ovf} !== {mq, mr, mdz, mov} || lat !== 16) begin
            errors++;
            $display("FAIL start_ignored_in_run got %h lat=%0d want %h lat=16", {quo, rem, dbz, ovf}, lat, {mq, mr, mdz, mov});
        end
        @(posedge clk);
        #1 start = 1'b0;
        checks++;
        if (done !== 1'b0 || dbz !== 1'b0 || quo !== mq) begin
            errors++;
            $display("FAIL start_ignored_in_done got done=%b dbz=%b q=%h want 0 0 %h", done, dbz, quo, mq);
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_reset_mid_run();
        int lat, bcnt, seen;
        logic [33:0] res;
        logic da;
        @(negedge clk);
        start = 1'b1; sgn = 1'b0; a = 16'd5000; b = 16'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, quo, rem, dbz, ovf} !== 36'h0) begin
            errors++;
            $display("FAIL async_reset got %h want 0", {busy, done, quo, rem, dbz, ovf});
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1 seen += int'(done) + int'(busy);
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_no_done got %0d activity cycles want 0", seen);
        end
        do_div(1'b0, 16'd9, 16'd3, lat, bcnt, res, da);
        checks++;
        if (res !== {16'd3, 16'd0, 1'b0, 1'b0} || lat !== 16) begin
            errors++;
            $display("FAIL after_reset_div got %h lat=%0d want %h lat=16", res, lat, {16'd3, 16'd0, 2'b00});
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
